// File: rtl/gb_pkg.sv
// Shared SM83 definitions: ALU opcodes, flag bit positions and the ALU sequencer states.
package gb_pkg;

   typedef enum logic [3:0] {
      OP_ADD = 4'd0,
      OP_ADC = 4'd1,
      OP_SUB = 4'd2,
      OP_SBC = 4'd3,
      OP_AND = 4'd4,
      OP_XOR = 4'd5,
      OP_OR  = 4'd6,
      OP_CP  = 4'd7,
      OP_INC = 4'd8,
      OP_DEC = 4'd9,
      OP_DAA = 4'd10
   } alu_op_e;

   localparam int FLAG_Z = 7;
   localparam int FLAG_N = 6;
   localparam int FLAG_H = 5;
   localparam int FLAG_C = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LO   = 2'd1,
      HI   = 2'd2,
      WB   = 2'd3
   } alu_state_e;

   // Opcodes that run the nibble adder in subtract mode.
   function automatic logic op_is_sub(input alu_op_e o);
      return (o == OP_SUB) || (o == OP_SBC) || (o == OP_CP) || (o == OP_DEC);
   endfunction

endpackage

// File: rtl/alu_nibble_add.sv
// 4-bit adder/subtractor shared by both ALU passes. ci_i/co_o are true carry
// when sub_i=0 and true borrow when sub_i=1.
module alu_nibble_add (
   input  logic [3:0] a_i,
   input  logic [3:0] b_i,
   input  logic       ci_i,
   input  logic       sub_i,
   output logic [3:0] sum_o,
   output logic       co_o
);

   logic [3:0] b_eff;
   logic       c_eff;
   logic [4:0] raw;

   // Subtraction as a + ~b + ~borrow; the raw carry is the inverted borrow.
   assign b_eff = sub_i ? ~b_i : b_i;
   assign c_eff = sub_i ? ~ci_i : ci_i;
   assign raw   = {1'b0, a_i} + {1'b0, b_eff} + {4'b0, c_eff};
   assign sum_o = raw[3:0];
   assign co_o  = sub_i ? ~raw[4] : raw[4];

endmodule

// File: rtl/alu_seq.sv
// Sequential SM83 ALU: two nibble passes (LO, HI) then writeback, owning flag register F.
// Optional DAA (opcode 10) is compiled in with `define ALU_DAA_EN.
module alu_seq
   import gb_pkg::*;
#(
   parameter int DW = 8,
   parameter int AW = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [3:0]    op,
   input  logic [AW-1:0] src1_addr,
   input  logic [AW-1:0] src2_addr,
   input  logic [AW-1:0] dst_addr,
   output logic          busy,
   output logic          done,
   output logic [AW-1:0] r1_addr,
   output logic [AW-1:0] r2_addr,
   input  logic [DW-1:0] r1,
   input  logic [DW-1:0] r2,
   output logic [DW-1:0] alu_res,
   output logic          alu_we,
   output logic [AW-1:0] alu_waddr,
   output logic [7:0]    f_out
);

   alu_state_e    state_q;
   alu_op_e       op_q;
   logic [AW-1:0] r1_addr_q, r2_addr_q, waddr_q;
   logic [DW-1:0] op1_q, op2_q;
   logic [3:0]    lo_q;
   logic          hc_q;
   logic [7:0]    f_q, f_new_q;
   logic          f_upd_q;
   logic [DW-1:0] res_q;
   logic          we_q, done_q;

   logic [3:0]    add_a, add_b, add_sum;
   logic          add_ci, add_co, add_sub, incdec;
   logic [DW-1:0] res_d;
   logic          we_d, upd_d, n_d, h_d, c_d;
   logic [7:0]    f_d;

   assign incdec  = (op_q == OP_INC) || (op_q == OP_DEC);
   assign add_sub = op_is_sub(op_q);

   // LO feeds the live regfile read; HI reuses the adder on the captured high nibbles.
   always_comb begin
      if (state_q == LO) begin
         add_a  = r1[3:0];
         add_b  = incdec ? 4'h1 : r2[3:0];
         add_ci = ((op_q == OP_ADC) || (op_q == OP_SBC)) & f_q[FLAG_C];
      end else begin
         add_a  = op1_q[7:4];
         add_b  = incdec ? 4'h0 : op2_q[7:4];
         add_ci = hc_q;
      end
   end

   alu_nibble_add u_nib (
      .a_i   (add_a),
      .b_i   (add_b),
      .ci_i  (add_ci),
      .sub_i (add_sub),
      .sum_o (add_sum),
      .co_o  (add_co)
   );

`ifdef ALU_DAA_EN
   logic          daa_lo, daa_hi;
   logic [DW-1:0] daa_corr, daa_res;
   logic          daa_c;

   // Decimal adjust: direction follows the N flag left by the previous op.
   always_comb begin
      if (!f_q[FLAG_N]) begin
         daa_lo = f_q[FLAG_H] | (op1_q[3:0] > 4'd9);
         daa_hi = f_q[FLAG_C] | (op1_q > 8'h99);
      end else begin
         daa_lo = f_q[FLAG_H];
         daa_hi = f_q[FLAG_C];
      end
      daa_corr = {(daa_hi ? 4'h6 : 4'h0), (daa_lo ? 4'h6 : 4'h0)};
      daa_res  = f_q[FLAG_N] ? (op1_q - daa_corr) : (op1_q + daa_corr);
      daa_c    = f_q[FLAG_N] ? f_q[FLAG_C] : daa_hi;
   end
`endif

   // HI-phase result and flag formation; only meaningful while state_q == HI.
   always_comb begin
      res_d = {add_sum, lo_q};
      we_d  = 1'b1;
      upd_d = 1'b1;
      n_d   = 1'b0;
      h_d   = hc_q;
      c_d   = add_co;
      case (op_q)
         OP_ADD, OP_ADC: ;
         OP_SUB, OP_SBC: n_d = 1'b1;
         OP_CP: begin
            n_d  = 1'b1;
            we_d = 1'b0;
         end
         OP_AND: begin
            res_d = op1_q & op2_q;
            h_d   = 1'b1;
            c_d   = 1'b0;
         end
         OP_XOR: begin
            res_d = op1_q ^ op2_q;
            h_d   = 1'b0;
            c_d   = 1'b0;
         end
         OP_OR: begin
            res_d = op1_q | op2_q;
            h_d   = 1'b0;
            c_d   = 1'b0;
         end
         OP_INC: c_d = f_q[FLAG_C];
         OP_DEC: begin
            n_d = 1'b1;
            c_d = f_q[FLAG_C];
         end
`ifdef ALU_DAA_EN
         OP_DAA: begin
            res_d = daa_res;
            n_d   = f_q[FLAG_N];
            h_d   = 1'b0;
            c_d   = daa_c;
         end
`endif
         default: begin
            we_d  = 1'b0;
            upd_d = 1'b0;
         end
      endcase
      f_d         = 8'h00;
      f_d[FLAG_Z] = (res_d == '0);
      f_d[FLAG_N] = n_d;
      f_d[FLAG_H] = h_d;
      f_d[FLAG_C] = c_d;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         op_q      <= OP_ADD;
         r1_addr_q <= '0;
         r2_addr_q <= '0;
         waddr_q   <= '0;
         op1_q     <= '0;
         op2_q     <= '0;
         lo_q      <= '0;
         hc_q      <= 1'b0;
         f_q       <= 8'h00;
         f_new_q   <= 8'h00;
         f_upd_q   <= 1'b0;
         res_q     <= '0;
         we_q      <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  state_q   <= LO;
                  op_q      <= alu_op_e'(op);
                  r1_addr_q <= src1_addr;
                  r2_addr_q <= src2_addr;
                  waddr_q   <= dst_addr;
               end
            end
            LO: begin
               op1_q   <= r1;
               op2_q   <= r2;
               lo_q    <= add_sum;
               hc_q    <= add_co;
               state_q <= HI;
            end
            HI: begin
               res_q   <= res_d;
               we_q    <= we_d;
               done_q  <= 1'b1;
               f_new_q <= f_d;
               f_upd_q <= upd_d;
               state_q <= WB;
            end
            WB: begin
               we_q    <= 1'b0;
               done_q  <= 1'b0;
               if (f_upd_q) f_q <= f_new_q;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy      = (state_q != IDLE);
   assign done      = done_q;
   assign r1_addr   = r1_addr_q;
   assign r2_addr   = r2_addr_q;
   assign alu_waddr = waddr_q;
   assign alu_res   = res_q;
   assign alu_we    = we_q;
   assign f_out     = f_q;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed SM83 cases plus randomized ops against an arithmetic model.
module tb_alu_seq;

   logic       clk = 1'b0;
   logic       rst, start;
   logic [3:0] op, src1, src2, dst;
   logic       busy, done, alu_we;
   logic [3:0] r1_addr, r2_addr, alu_waddr;
   logic [7:0] r1, r2, alu_res, f_out;

   logic [7:0] regs [16];
   logic [7:0] fm;
   int         n_vec = 0;
   int         n_err = 0;

   assign r1 = regs[r1_addr];
   assign r2 = regs[r2_addr];

   always #5 clk = ~clk;

   alu_seq #(.DW(8), .AW(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .op        (op),
      .src1_addr (src1),
      .src2_addr (src2),
      .dst_addr  (dst),
      .busy      (busy),
      .done      (done),
      .r1_addr   (r1_addr),
      .r2_addr   (r2_addr),
      .r1        (r1),
      .r2        (r2),
      .alu_res   (alu_res),
      .alu_we    (alu_we),
      .alu_waddr (alu_waddr),
      .f_out     (f_out)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference: plain integer arithmetic on the SM83 flag rules.
   function automatic void model(input logic [3:0] o, input logic [7:0] a, input logic [7:0] b,
                                 input logic [7:0] f, output logic [7:0] res,
                                 output logic we, output logic [7:0] fn);
      int ai, bi, ci, s, corr;
      logic n, h, c, valid;
      ai = int'(a); bi = int'(b); ci = 0; s = 0; corr = 0;
      n = 1'b0; h = 1'b0; c = 1'b0; we = 1'b1; valid = 1'b1;
      case (o)
         4'd0, 4'd1: begin
            ci = (o == 4'd1) ? int'(f[4]) : 0;
            s  = ai + bi + ci;
            h  = (ai % 16 + bi % 16 + ci) > 15;
            c  = s > 255;
         end
         4'd2, 4'd3, 4'd7: begin
            ci = (o == 4'd3) ? int'(f[4]) : 0;
            s  = ai - bi - ci;
            n  = 1'b1;
            h  = (ai % 16) < (bi % 16 + ci);
            c  = ai < (bi + ci);
            we = (o != 4'd7);
         end
         4'd4: begin s = ai & bi; h = 1'b1; end
         4'd5: s = ai ^ bi;
         4'd6: s = ai | bi;
         4'd8: begin s = ai + 1; h = (ai % 16) == 15; c = f[4]; end
         4'd9: begin s = ai - 1; n = 1'b1; h = (ai % 16) == 0; c = f[4]; end
`ifdef ALU_DAA_EN
         4'd10: begin
            n = f[6];
            c = f[4];
            if (!f[6]) begin
               if (f[5] || (ai % 16) > 9) corr += 6;
               if (f[4] || ai > 153) begin corr += 96; c = 1'b1; end
               s = ai + corr;
            end else begin
               if (f[5]) corr += 6;
               if (f[4]) corr += 96;
               s = ai - corr;
            end
         end
`endif
         default: begin we = 1'b0; valid = 1'b0; end
      endcase
      res = s[7:0];
      fn  = valid ? {(res == 8'h00), n, h, c, 4'h0} : f;
   endfunction

   // One full operation, cycle-by-cycle; poke re-asserts start during HI.
   task automatic run_op(input logic [3:0] o, input logic [3:0] s1, input logic [3:0] s2,
                         input logic [3:0] d, input bit poke);
      logic [7:0] er, ef;
      logic       ew;
      model(o, regs[s1], regs[s2], fm, er, ew, ef);
      @(negedge clk);
      start = 1'b1; op = o; src1 = s1; src2 = s2; dst = d;
      @(negedge clk);
      start = 1'b0; op = 4'($urandom); src1 = 4'($urandom); src2 = 4'($urandom); dst = 4'($urandom);
      check("lo_busy", busy, 1'b1);
      check("lo_we", alu_we, 1'b0);
      check("lo_r1a", r1_addr, s1);
      check("lo_r2a", r2_addr, s2);
      @(negedge clk);
      check("hi_we", alu_we, 1'b0);
      check("hi_done", done, 1'b0);
      check("hi_waddr", alu_waddr, d);
      if (poke) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("wb_done", done, 1'b1);
      check("wb_busy", busy, 1'b1);
      check("wb_we", alu_we, ew);
      check("wb_waddr", alu_waddr, d);
      if (ew) check("wb_res", alu_res, er);
      if (alu_we) regs[alu_waddr] = alu_res;
      @(negedge clk);
      check("post_done", done, 1'b0);
      check("post_busy", busy, 1'b0);
      check("post_we", alu_we, 1'b0);
      check("post_f", f_out, ef);
      fm = ef;
      if (poke) begin
         repeat (4) begin
            @(negedge clk);
            check("poke_done", done, 1'b0);
            check("poke_busy", busy, 1'b0);
         end
      end
   endtask

   initial begin
      logic [7:0] pre;
      for (int i = 0; i < 16; i++) regs[i] = 8'($urandom);
      fm = 8'h00;
      rst = 1'b0; start = 1'b0; op = 4'h0; src1 = 4'h0; src2 = 4'h0; dst = 4'h0;
      #1;
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_we", alu_we, 1'b0);
      check("rst_f", f_out, 8'h00);
      check("rst_res", alu_res, 8'h00);
      check("rst_addr", {r1_addr, r2_addr, alu_waddr}, 12'h000);
      repeat (2) @(negedge clk);
      rst = 1'b1;

      regs[3] = 8'h3A; regs[4] = 8'hC6;
      run_op(4'd0, 4'd3, 4'd4, 4'd2, 1'b0);
      check("add_res", regs[2], 8'h00);
      check("add_f", f_out, 8'hB0);

      regs[5] = 8'h3E; regs[6] = 8'h0F;
      run_op(4'd2, 4'd5, 4'd6, 4'd7, 1'b0);
      check("sub_res", regs[7], 8'h2F);
      check("sub_f", f_out, 8'h60);

      regs[8] = 8'h3C; regs[9] = 8'h40; pre = regs[10];
      run_op(4'd7, 4'd8, 4'd9, 4'd10, 1'b0);
      check("cp_nowrite", regs[10], pre);
      check("cp_f", f_out, 8'h50);

      run_op(4'd0, 4'd3, 4'd4, 4'd2, 1'b0);
      regs[11] = 8'hFF;
      run_op(4'd8, 4'd11, 4'd0, 4'd12, 1'b0);
      check("inc_res", regs[12], 8'h00);
      check("inc_f", f_out, 8'hB0);
      regs[13] = 8'h01;
      run_op(4'd9, 4'd13, 4'd0, 4'd14, 1'b0);
      check("dec_res", regs[14], 8'h00);
      check("dec_f", f_out, 8'hD0);

      run_op(4'd4, 4'd3, 4'd4, 4'd1, 1'b1);

      // Reset during HI aborts the op: no write, flags cleared at once.
      regs[3] = 8'h3A; regs[4] = 8'hC6; pre = regs[15];
      @(negedge clk);
      start = 1'b1; op = 4'd0; src1 = 4'd3; src2 = 4'd4; dst = 4'd15;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("abort_busy", busy, 1'b0);
      check("abort_we", alu_we, 1'b0);
      check("abort_f", f_out, 8'h00);
      check("abort_done", done, 1'b0);
      repeat (2) begin
         @(negedge clk);
         check("abort_hold_we", alu_we, 1'b0);
      end
      rst = 1'b1;
      fm = 8'h00;
      check("abort_nowrite", regs[15], pre);

      regs[3] = 8'h45; regs[4] = 8'h38;
      run_op(4'd0, 4'd3, 4'd4, 4'd5, 1'b0);
      check("bcd_add_res", regs[5], 8'h7D);
      check("bcd_add_f", f_out, 8'h00);
      pre = regs[6];
      run_op(4'd10, 4'd5, 4'd0, 4'd6, 1'b0);
`ifdef ALU_DAA_EN
      check("daa_res", regs[6], 8'h83);
`else
      check("daa_nowrite", regs[6], pre);
`endif
      check("daa_f", f_out, 8'h00);

      for (int k = 0; k < 80; k++) begin
         if (k % 4 == 0) regs[4'($urandom)] = 8'($urandom);
         run_op(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 1'b0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/alu_seq.md
# alu_seq

Sequential SM83 ALU sitting directly downstream of `regfile`'s read ports and upstream of its ALU write port. Accepts one operation per request, reads two 8-bit operands via `r1_addr`/`r2_addr`, computes the result as two 4-bit passes (low nibble, then high nibble with carry), and writes it back through `alu_res`/`alu_we`/`alu_waddr`. Owns the flag register F (Z N H C) and completes one operation per 4-cycle M-cycle.

## Interface
Parameters:
- `DW`, 8, datapath width; only 8 is supported.
- `AW`, 4, register-address width, matching `regfile`.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; accepted only in IDLE.
- `op`  in  4  `alu_op_e` opcode, sampled on accept.
- `src1_addr`, `src2_addr`  in  AW  operand register addresses, sampled on accept.
- `dst_addr`  in  AW  destination address, sampled on accept.
- `busy`  out  1  high in LO, HI and WB.
- `done`  out  1  one-cycle pulse in WB.
- `r1_addr`, `r2_addr`  out  AW  latched source addresses to `regfile`.
- `r1`, `r2`  in  DW  operands from `regfile` (combinational read).
- `alu_res`  out  DW  result.
- `alu_we`  out  1  write enable to `regfile`.
- `alu_waddr`  out  AW  latched `dst_addr`.
- `f_out`  out  8  F register: bit7 Z, bit6 N, bit5 H, bit4 C; bits 3:0 are always 0.

## Operation
- FSM states: IDLE → LO → HI → WB → IDLE.
  - IDLE→LO on `start`.
  - All other transitions are unconditional.
- LO: capture `r1`/`r2`; compute bits 3:0 and the half-carry/borrow out of bit 3.
- HI: compute bits 7:4 using the carry-in from LO; form the carry/borrow out of bit 7.
- WB:
  - Drive `alu_res` and assert `alu_we`.
  - Update F on the WB clock edge.
  - Pulse `done`.
- Opcodes and F updates:
  - ADD=0, ADC=1: N=0; H = carry from bit3; C = carry from bit7. ADC adds the old C.
  - SUB=2, SBC=3, CP=7: N=1; H = borrow from bit4; C = borrow. SBC subtracts the old C.
  - CP writes no result: `alu_we` stays 0 in WB.
  - AND=4: H=1, N=0, C=0.
  - XOR=5, OR=6: N=H=C=0.
  - INC=8, DEC=9: operand is `r1` only, ±1. N = (op==DEC). H as for add/sub. C unchanged.
  - Z = (8-bit result == 0) for every valid opcode.
- Opcodes 10–15 are illegal (10 only when DAA is compiled out):
  - FSM still runs the full sequence and `done` pulses.
  - `alu_we` stays 0 and F is unchanged.
- `start` while busy is ignored. There is no queueing.

## Timing
- Accept edge N (IDLE, `start`=1) → LO in cycle N+1, HI in N+2, WB in N+3.
- The regfile write happens on the rising edge that ends N+3. The next `start` is accepted in N+4.
- `r1_addr`/`r2_addr`/`alu_waddr` are stable from N+1 until the next accept.
- Reset values: state IDLE, F=0x00, `alu_res`=0, `alu_we`=0, `done`=0, `busy`=0, all addresses 0.
- Reset asserted mid-operation aborts immediately. No write occurs and F clears.
- `alu_res` holds its last value outside WB. Only `alu_we` qualifies it.

## Configuration
- `ALU_DAA_EN` defined: opcode 10 = DAA on `r1`, computed in HI.
  - If N=0: add 0x06 if H or low nibble > 9; add 0x60 and set C if C or value > 0x99.
  - If N=1: subtract 0x06 if H; subtract 0x60 if C.
  - Resulting flags: Z updated, H=0, N unchanged.
- `ALU_DAA_EN` undefined: opcode 10 is illegal (see Operation).

## Structure
- `gb_pkg` holds:
  - `alu_op_e` enum.
  - Flag bit-index constants `FLAG_Z`, `FLAG_N`, `FLAG_H`, `FLAG_C`.
  - `alu_state_e` (IDLE, LO, HI, WB).
- One sub-module, `alu_nibble_add`: 4-bit add/subtract with carry-in, carry-out and a sub select. It is instantiated once and reused by LO and HI.

## Test plan
- ADD, r1=0x3A, r2=0xC6, dst=2 → `alu_we`=1 only in cycle N+3, `alu_waddr`=2, `alu_res`=0x00, F=0xB0.
- SUB, 0x3E−0x0F → `alu_res`=0x2F, F=0x60. Then CP, 0x3C vs 0x40 → `alu_we` never asserts, F=0x50.
- Set C via the ADD case, then INC r1=0xFF → `alu_res`=0x00, F=0xB0 (C retained). DEC 0x01 → 0x00, F=0xD0.
- `start` pulsed in N+2 of a running op → ignored, `done` pulses exactly once. Then `rst`=0 during HI → no `alu_we`, F=0x00, `busy`=0 immediately.
- With `ALU_DAA_EN`: ADD 0x45+0x38 → 0x7D, then DAA → `alu_res`=0x83, F=0x00.
- Without `ALU_DAA_EN`: the same DAA → no write, F stays 0x00, `done` pulses at N+3.
